decode_stage: RTL

Decode stage of the five-stage RV32I pipeline, directly downstream of the fetch stage. It holds the IF/ID pipeline register, decodes the instruction, and generates immediates. It drives register-file read addresses and registers the control and data bundle into the ID/EX register for execute. It also detects load-use hazards and drives `stallF_N` back to fetch.

---
 rtl/decode_pkg.sv | 62 ++++++
 rtl/main_decoder.sv | 130 +++++++++++++
 rtl/decode_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
//==============================================================================
// Module      : decode_pkg
// Description : Shared opcodes, ALU/result codes, immediate kinds and the
//               ID/EX control bundle for the RV32I decode stage.
//               DECODE_ILLEGAL_EN adds the illegal flag to the bundle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_type_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
`ifdef DECODE_ILLEGAL_EN
        logic       illegal;
`endif
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/main_decoder.sv
//==============================================================================
// Module      : main_decoder
// Description : Combinational opcode/funct3/funct7 decoder producing the
//               control bundle, immediate kind, source usage and legality.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module main_decoder
    import decode_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output logic       o_reg_write,
    output logic [1:0] o_result_src,
    output logic       o_mem_write,
    output logic       o_jump,
    output logic       o_branch,
    output logic [2:0] o_alu_control,
    output logic       o_alu_src,
    output imm_type_t  o_imm_type,
    output logic       o_use_rs1,
    output logic       o_use_rs2,
    output logic       o_illegal
);

    logic [2:0] w_alu_f3;
    logic       w_f3_ok;
    logic       w_shift;
    logic       w_legal;

    // funct3 -> ALU op shared by R-type and I-type; 011 (sltu) is unsupported
    always_comb begin
        w_f3_ok  = 1'b1;
        w_alu_f3 = ALU_ADD;
        case (i_funct3)
            3'b000:  w_alu_f3 = ALU_ADD;
            3'b001:  w_alu_f3 = ALU_SLL;
            3'b010:  w_alu_f3 = ALU_SLT;
            3'b100:  w_alu_f3 = ALU_XOR;
            3'b101:  w_alu_f3 = ALU_SRL;
            3'b110:  w_alu_f3 = ALU_OR;
            3'b111:  w_alu_f3 = ALU_AND;
            default: w_f3_ok  = 1'b0;
        endcase
    end

    assign w_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);

    always_comb begin
        o_reg_write   = 1'b0;
        o_result_src  = RES_ALU;
        o_mem_write   = 1'b0;
        o_jump        = 1'b0;
        o_branch      = 1'b0;
        o_alu_control = ALU_ADD;
        o_alu_src     = 1'b0;
        o_imm_type    = IMM_I;
        o_use_rs1     = 1'b0;
        o_use_rs2     = 1'b0;
        w_legal       = 1'b0;
        case (i_opcode)
            OP_LOAD: if (i_funct3 == 3'b010) begin
                w_legal      = 1'b1;
                o_reg_write  = 1'b1;
                o_result_src = RES_MEM;
                o_alu_src    = 1'b1;
                o_use_rs1    = 1'b1;
            end
            OP_STORE: if (i_funct3 == 3'b010) begin
                w_legal     = 1'b1;
                o_mem_write = 1'b1;
                o_alu_src   = 1'b1;
                o_imm_type  = IMM_S;
                o_use_rs1   = 1'b1;
                o_use_rs2   = 1'b1;
            end
            OP_RTYPE: begin
                if (w_f3_ok && i_funct7 == 7'b0000000) begin
                    w_legal       = 1'b1;
                    o_alu_control = w_alu_f3;
                end else if (i_funct3 == 3'b000 && i_funct7 == 7'b0100000) begin
                    w_legal       = 1'b1;
                    o_alu_control = ALU_SUB;
                end
                if (w_legal) begin
                    o_reg_write = 1'b1;
                    o_use_rs1   = 1'b1;
                    o_use_rs2   = 1'b1;
                end
            end
            // funct7 only qualifies the shifts; srai is deliberately rejected
            OP_ITYPE: if (w_f3_ok && (!w_shift || i_funct7 == 7'b0000000)) begin
                w_legal       = 1'b1;
                o_reg_write   = 1'b1;
                o_alu_src     = 1'b1;
                o_alu_control = w_alu_f3;
                o_use_rs1     = 1'b1;
            end
            OP_BRANCH: if (i_funct3 == 3'b000) begin
                w_legal       = 1'b1;
                o_branch      = 1'b1;
                o_alu_control = ALU_SUB;
                o_imm_type    = IMM_B;
                o_use_rs1     = 1'b1;
                o_use_rs2     = 1'b1;
            end
            OP_JAL: begin
                w_legal      = 1'b1;
                o_jump       = 1'b1;
                o_reg_write  = 1'b1;
                o_result_src = RES_PC4;
                o_imm_type   = IMM_J;
            end
            OP_LUI: begin
                w_legal     = 1'b1;
                o_reg_write = 1'b1;
                o_alu_src   = 1'b1;
                o_imm_type  = IMM_U;
            end
            default: ;
        endcase
    end

    assign o_illegal = ~w_legal;

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
//==============================================================================
// Module      : decode_stage
// Description : RV32I decode stage: IF/ID register, decode, immediates,
//               load-use hazard and ID/EX register. DECODE_ILLEGAL_EN adds
//               the registered illegalE output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module decode_stage
    import decode_pkg::*;
#(
    parameter int counter_width = 32,
    parameter int word_width    = 32
) (
    input  logic                     clk,
    input  logic                     reset_N,
    input  logic [word_width-1:0]    instrF,
    input  logic [counter_width-1:0] PCF,
    input  logic [counter_width-1:0] PCPlus4F,
    input  logic                     PCSrcE,
    input  logic [word_width-1:0]    rd1D,
    input  logic [word_width-1:0]    rd2D,
    output logic [4:0]               rs1D,
    output logic [4:0]               rs2D,
    output logic                     stallF_N,
    output logic                     validE,
    output logic                     RegWriteE,
    output logic                     MemWriteE,
    output logic                     JumpE,
    output logic                     BranchE,
    output logic                     ALUSrcE,
    output logic [1:0]               ResultSrcE,
    output logic [2:0]               ALUControlE,
    output logic [word_width-1:0]    RD1E,
    output logic [word_width-1:0]    RD2E,
    output logic [word_width-1:0]    ImmExtE,
    output logic [counter_width-1:0] PCE,
    output logic [counter_width-1:0] PCPlus4E,
    output logic [4:0]               Rs1E,
    output logic [4:0]               Rs2E,
`ifdef DECODE_ILLEGAL_EN
    output logic                     illegalE,
`endif
    output logic [4:0]               RdE
);

    logic [word_width-1:0]    r_instr_d;
    logic [counter_width-1:0] r_pc_d;
    logic [counter_width-1:0] r_pc_plus4_d;
    logic                     r_valid_d;

    id_ex_t                   r_ctrl_e;
    id_ex_t                   w_ctrl_d;
    logic [word_width-1:0]    r_rd1_e;
    logic [word_width-1:0]    r_rd2_e;
    logic [word_width-1:0]    r_imm_e;
    logic [counter_width-1:0] r_pc_e;
    logic [counter_width-1:0] r_pc_plus4_e;

    logic       w_reg_write;
    logic [1:0] w_result_src;
    logic       w_mem_write;
    logic       w_jump;
    logic       w_branch;
    logic [2:0] w_alu_control;
    logic       w_alu_src;
    imm_type_t  w_imm_type;
    logic       w_use_rs1;
    logic       w_use_rs2;
    logic       w_illegal;

    logic [31:0]           w_instr;
    logic [4:0]            w_rs1_d;
    logic [4:0]            w_rs2_d;
    logic [31:0]           w_imm32;
    logic [word_width-1:0] w_imm;
    logic                  w_lw_stall;
    logic                  w_bubble;

    assign w_instr = r_instr_d[31:0];

    main_decoder u_main_decoder (
        .i_opcode      (w_instr[6:0]),
        .i_funct3      (w_instr[14:12]),
        .i_funct7      (w_instr[31:25]),
        .o_reg_write   (w_reg_write),
        .o_result_src  (w_result_src),
        .o_mem_write   (w_mem_write),
        .o_jump        (w_jump),
        .o_branch      (w_branch),
        .o_alu_control (w_alu_control),
        .o_alu_src     (w_alu_src),
        .o_imm_type    (w_imm_type),
        .o_use_rs1     (w_use_rs1),
        .o_use_rs2     (w_use_rs2),
        .o_illegal     (w_illegal)
    );

    // lui reads x0 so the ALU's add yields the bare U immediate
    assign w_rs1_d = (w_imm_type == IMM_U) ? 5'd0 : w_instr[19:15];
    assign w_rs2_d = w_instr[24:20];
    assign rs1D    = w_rs1_d;
    assign rs2D    = w_rs2_d;

    always_comb begin
        w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
        case (w_imm_type)
            IMM_S:   w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            IMM_B:   w_imm32 = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25],
                                w_instr[11:8], 1'b0};
            IMM_J:   w_imm32 = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20],
                                w_instr[30:21], 1'b0};
            IMM_U:   w_imm32 = {w_instr[31:12], 12'b0};
            default: w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]};
        endcase
    end

    assign w_imm = word_width'(signed'(w_imm32));

    // Only sources a legal instruction actually reads can create a hazard
    assign w_lw_stall = ~PCSrcE & r_ctrl_e.valid
                      & (r_ctrl_e.result_src == RES_MEM)
                      & (r_ctrl_e.rd != 5'd0)
                      & ~w_illegal
                      & ((w_use_rs1 & (r_ctrl_e.rd == w_rs1_d)) |
                         (w_use_rs2 & (r_ctrl_e.rd == w_rs2_d)));

    assign w_bubble = PCSrcE | w_lw_stall;
    assign stallF_N = ~w_lw_stall;

    always_comb begin
        w_ctrl_d             = '0;
        w_ctrl_d.valid       = r_valid_d;
        w_ctrl_d.reg_write   = w_reg_write;
        w_ctrl_d.result_src  = w_result_src;
        w_ctrl_d.mem_write   = w_mem_write;
        w_ctrl_d.jump        = w_jump;
        w_ctrl_d.branch      = w_branch;
        w_ctrl_d.alu_control = w_alu_control;
        w_ctrl_d.alu_src     = w_alu_src;
`ifdef DECODE_ILLEGAL_EN
        w_ctrl_d.illegal     = w_illegal & r_valid_d;
`endif
        w_ctrl_d.rs1         = w_rs1_d;
        w_ctrl_d.rs2         = w_rs2_d;
        w_ctrl_d.rd          = w_instr[11:7];
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_instr_d    <= word_width'(NOP_INSTR);
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (PCSrcE) begin
            r_instr_d <= word_width'(NOP_INSTR);
            r_valid_d <= 1'b0;
        end else if (!w_lw_stall) begin
            r_instr_d    <= instrF;
            r_pc_d       <= PCF;
            r_pc_plus4_d <= PCPlus4F;
            r_valid_d    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_ctrl_e     <= '0;
            r_rd1_e      <= '0;
            r_rd2_e      <= '0;
            r_imm_e      <= '0;
            r_pc_e       <= '0;
            r_pc_plus4_e <= '0;
        end else begin
            if (w_bubble) begin
                r_ctrl_e <= '0;
            end else begin
                r_ctrl_e <= w_ctrl_d;
            end
            r_rd1_e      <= rd1D;
            r_rd2_e      <= rd2D;
            r_imm_e      <= w_imm;
            r_pc_e       <= r_pc_d;
            r_pc_plus4_e <= r_pc_plus4_d;
        end
    end

    assign validE      = r_ctrl_e.valid;
    assign RegWriteE   = r_ctrl_e.reg_write;
    assign MemWriteE   = r_ctrl_e.mem_write;
    assign JumpE       = r_ctrl_e.jump;
    assign BranchE     = r_ctrl_e.branch;
    assign ALUSrcE     = r_ctrl_e.alu_src;
    assign ResultSrcE  = r_ctrl_e.result_src;
    assign ALUControlE = r_ctrl_e.alu_control;
    assign Rs1E        = r_ctrl_e.rs1;
    assign Rs2E        = r_ctrl_e.rs2;
    assign RdE         = r_ctrl_e.rd;
`ifdef DECODE_ILLEGAL_EN
    assign illegalE    = r_ctrl_e.illegal;
`endif
    assign RD1E        = r_rd1_e;
    assign RD2E        = r_rd2_e;
    assign ImmExtE     = r_imm_e;
    assign PCE         = r_pc_e;
    assign PCPlus4E    = r_pc_plus4_e;

endmodule

`default_nettype wire
